// File: rtl/traffic_light_pkg.sv
// traffic_light_pkg: shared types and helpers for the intersection controller.
// Build option: ALL_RED_EN adds the two all-red clearance states to the enum.
package traffic_light_pkg;

  localparam int DEF_GREEN_CYCLES   = 10;
  localparam int DEF_YELLOW_CYCLES  = 3;
  localparam int DEF_ALL_RED_CYCLES = 2;

`ifdef ALL_RED_EN
  typedef enum logic [2:0] {
    NS_GREEN     = 3'd0,
    NS_YELLOW    = 3'd1,
    ALLRED_TO_EW = 3'd2,
    EW_GREEN     = 3'd3,
    EW_YELLOW    = 3'd4,
    ALLRED_TO_NS = 3'd5
  } state_t;
`else
  typedef enum logic [1:0] {
    NS_GREEN  = 2'd0,
    NS_YELLOW = 2'd1,
    EW_GREEN  = 2'd2,
    EW_YELLOW = 2'd3
  } state_t;
`endif

  typedef struct packed {
    logic red;
    logic yellow;
    logic green;
  } lamp_t;

  typedef struct packed {
    lamp_t ns;
    lamp_t ew;
  } lamps_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Lamp pattern for each state; anything unexpected shows red both ways.
  function automatic lamps_t lamp_decode(input state_t s);
    lamps_t l;
    l = '0;
    case (s)
      NS_GREEN:     begin l.ns.green  = 1'b1; l.ew.red = 1'b1; end
      NS_YELLOW:    begin l.ns.yellow = 1'b1; l.ew.red = 1'b1; end
      EW_GREEN:     begin l.ew.green  = 1'b1; l.ns.red = 1'b1; end
      EW_YELLOW:    begin l.ew.yellow = 1'b1; l.ns.red = 1'b1; end
      default:      begin l.ns.red    = 1'b1; l.ew.red = 1'b1; end
    endcase
    return l;
  endfunction

endpackage

// File: rtl/tl_phase_timer.sv
// tl_phase_timer: phase cycle counter. Cleared by load (state entry) or
// reset, counts every edge otherwise; done flags the last cycle of a phase.
module tl_phase_timer
  import traffic_light_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load,
  input  logic [CNT_W:0] len,
  output logic           done
);

  logic [CNT_W-1:0] cnt;

  // Count cycles spent in the current phase; restart on every state entry.
  always_ff @(posedge clk) begin
    if (reset || load) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // len is one bit wider than cnt so a phase length of 2**CNT_W still fits.
  assign done = ({1'b0, cnt} == (len - 1'b1));

endmodule

// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: fixed-time two-way intersection controller.
// Build option: define ALL_RED_EN to insert all-red clearance phases
// between each yellow and the opposite green.
//
// state        | meaning
// NS_GREEN     | north-south go, east-west red
// NS_YELLOW    | north-south clearing, east-west red
// ALLRED_TO_EW | both red before east-west green (ALL_RED_EN only)
// EW_GREEN     | east-west go, north-south red
// EW_YELLOW    | east-west clearing, north-south red
// ALLRED_TO_NS | both red before north-south green (ALL_RED_EN only)
module traffic_light_ctrl
  import traffic_light_pkg::*;
#(
  parameter int GREEN_CYCLES   = DEF_GREEN_CYCLES,
  parameter int YELLOW_CYCLES  = DEF_YELLOW_CYCLES,
  parameter int ALL_RED_CYCLES = DEF_ALL_RED_CYCLES
) (
  input  logic clk,
  input  logic reset,
  output logic ns_red,
  output logic ns_yellow,
  output logic ns_green,
  output logic ew_red,
  output logic ew_yellow,
  output logic ew_green
);

  localparam int MAX_LEN = max_int(max_int(GREEN_CYCLES, YELLOW_CYCLES), ALL_RED_CYCLES);
  localparam int CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int LEN_W   = CNT_W + 1;

  state_t           state;
  state_t           next_state;
  logic [LEN_W-1:0] phase_len;
  logic             load;
  logic             done;
  lamps_t           lamps;

  // State register; reset forces north-south green.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= NS_GREEN;
    end else begin
      state <= next_state;
    end
  end

  // Phase length of the current state and the next state when it expires.
  always_comb begin
    next_state = state;
    phase_len  = LEN_W'(GREEN_CYCLES);
    case (state)
      NS_GREEN: begin
        phase_len = LEN_W'(GREEN_CYCLES);
        if (done) next_state = NS_YELLOW;
      end
      NS_YELLOW: begin
        phase_len = LEN_W'(YELLOW_CYCLES);
`ifdef ALL_RED_EN
        if (done) next_state = ALLRED_TO_EW;
`else
        if (done) next_state = EW_GREEN;
`endif
      end
`ifdef ALL_RED_EN
      ALLRED_TO_EW: begin
        phase_len = LEN_W'(ALL_RED_CYCLES);
        if (done) next_state = EW_GREEN;
      end
`endif
      EW_GREEN: begin
        phase_len = LEN_W'(GREEN_CYCLES);
        if (done) next_state = EW_YELLOW;
      end
      EW_YELLOW: begin
        phase_len = LEN_W'(YELLOW_CYCLES);
`ifdef ALL_RED_EN
        if (done) next_state = ALLRED_TO_NS;
`else
        if (done) next_state = NS_GREEN;
`endif
      end
`ifdef ALL_RED_EN
      ALLRED_TO_NS: begin
        phase_len = LEN_W'(ALL_RED_CYCLES);
        if (done) next_state = NS_GREEN;
      end
`endif
      default: next_state = NS_GREEN;
    endcase
  end

  // Any state change, including illegal-state recovery, restarts the timer.
  assign load = (next_state != state);

  tl_phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .len   (phase_len),
    .done  (done)
  );

  assign lamps     = lamp_decode(state);
  assign ns_red    = lamps.ns.red;
  assign ns_yellow = lamps.ns.yellow;
  assign ns_green  = lamps.ns.green;
  assign ew_red    = lamps.ew.red;
  assign ew_yellow = lamps.ew.yellow;
  assign ew_green  = lamps.ew.green;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// tb_traffic_light_ctrl: directed checks of the default controller and a
// one-cycle-phase instance, plus a mid-phase reset sequence.
module tb_traffic_light_ctrl;

  localparam logic [5:0] L_NSG = 6'b001_100;
  localparam logic [5:0] L_NSY = 6'b010_100;
  localparam logic [5:0] L_EWG = 6'b100_001;
  localparam logic [5:0] L_EWY = 6'b100_010;
  localparam logic [5:0] L_AR  = 6'b100_100;

  typedef struct {
    int         t;
    logic [5:0] exp_main;
    logic [5:0] exp_fast;
  } vec_t;

  logic clk;
  logic reset;
  logic ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green;
  logic f_ns_red, f_ns_yellow, f_ns_green, f_ew_red, f_ew_yellow, f_ew_green;
  logic [5:0] lamps;
  logic [5:0] f_lamps;

  int checks = 0;
  int errors = 0;

  vec_t vecs[$];

  traffic_light_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .ns_red    (ns_red),
    .ns_yellow (ns_yellow),
    .ns_green  (ns_green),
    .ew_red    (ew_red),
    .ew_yellow (ew_yellow),
    .ew_green  (ew_green)
  );

  traffic_light_ctrl #(
    .GREEN_CYCLES   (1),
    .YELLOW_CYCLES  (1),
    .ALL_RED_CYCLES (1)
  ) dut_fast (
    .clk       (clk),
    .reset     (reset),
    .ns_red    (f_ns_red),
    .ns_yellow (f_ns_yellow),
    .ns_green  (f_ns_green),
    .ew_red    (f_ew_red),
    .ew_yellow (f_ew_yellow),
    .ew_green  (f_ew_green)
  );

  assign lamps   = {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green};
  assign f_lamps = {f_ns_red, f_ns_yellow, f_ns_green, f_ew_red, f_ew_yellow, f_ew_green};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Lamp safety on both instances every cycle once the first edge has occurred.
  always @(negedge clk) begin
    if ($time > 8) begin
      checks++;
      if (!($onehot(lamps[5:3]) && $onehot(lamps[2:0]) && (lamps[5] | lamps[2]))) begin
        errors++;
        $display("FAIL safety_main at t=%0t: got %b expected one-hot per side with a red", $time, lamps);
      end
      checks++;
      if (!($onehot(f_lamps[5:3]) && $onehot(f_lamps[2:0]) && (f_lamps[5] | f_lamps[2]))) begin
        errors++;
        $display("FAIL safety_fast at t=%0t: got %b expected one-hot per side with a red", $time, f_lamps);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;

`ifdef ALL_RED_EN
    vecs.push_back('{15,  L_NSG, L_NSG});
    vecs.push_back('{105, L_NSG, L_EWG});
    vecs.push_back('{115, L_NSY, L_EWY});
    vecs.push_back('{135, L_NSY, L_NSG});
    vecs.push_back('{145, L_AR,  L_NSY});
    vecs.push_back('{155, L_AR,  L_AR });
    vecs.push_back('{165, L_EWG, L_EWG});
    vecs.push_back('{255, L_EWG, L_NSG});
    vecs.push_back('{265, L_EWY, L_NSY});
    vecs.push_back('{285, L_EWY, L_EWG});
    vecs.push_back('{295, L_AR,  L_EWY});
    vecs.push_back('{305, L_AR,  L_AR });
    vecs.push_back('{315, L_NSG, L_NSG});
    vecs.push_back('{415, L_NSY, L_EWY});
`else
    vecs.push_back('{15,   L_NSG, L_NSG});
    vecs.push_back('{105,  L_NSG, L_NSY});
    vecs.push_back('{115,  L_NSY, L_EWG});
    vecs.push_back('{135,  L_NSY, L_NSG});
    vecs.push_back('{145,  L_EWG, L_NSY});
    vecs.push_back('{235,  L_EWG, L_EWG});
    vecs.push_back('{245,  L_EWY, L_EWY});
    vecs.push_back('{265,  L_EWY, L_NSY});
    vecs.push_back('{275,  L_NSG, L_EWG});
    vecs.push_back('{365,  L_NSG, L_EWY});
    vecs.push_back('{375,  L_NSY, L_NSG});
    vecs.push_back('{405,  L_EWG, L_EWY});
    vecs.push_back('{505,  L_EWY, L_NSY});
    vecs.push_back('{535,  L_NSG, L_NSG});
    vecs.push_back('{1055, L_NSG, L_NSG});
    vecs.push_back('{1145, L_NSG, L_NSY});
    vecs.push_back('{1155, L_NSY, L_EWG});
    vecs.push_back('{1185, L_EWG, L_NSY});
`endif

    reset = 1'b1;
    #20;
    reset = 1'b0;

    // Sample 1 time unit after each listed rising edge.
    foreach (vecs[i]) begin
      if ($time < vecs[i].t + 1) #(vecs[i].t + 1 - $time);
      check("sched_main", lamps, vecs[i].exp_main);
      check("sched_fast", f_lamps, vecs[i].exp_fast);
    end

    // Mid-phase reset: find east-west green, move into its middle, reset.
    found = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (lamps == L_EWG) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL find_ew_green: got no EW_GREEN within 40 cycles, expected one");
    end
    repeat (3) @(negedge clk);
    check("midreset_pre", lamps, L_EWG);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_c0", lamps, L_NSG);
    for (int j = 1; j < 10; j++) begin
      @(negedge clk);
      check("midreset_green", lamps, L_NSG);
    end
    @(negedge clk);
    check("midreset_yellow", lamps, L_NSY);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
